// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for a shared 4:1 data mux with burst-limited grants and a valid/ready output.
// Optional build macro MUX_RR_LOCK_EN adds i_Lock, which keeps the current grant past the burst limit.
module mux_rr_scheduler #(
  parameter int WIDTH = 4,
  parameter int BURST = 4,
  parameter int CNT_W = 3
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [3:0]       i_Req,
  input  logic [WIDTH-1:0] i_Datos_0,
  input  logic [WIDTH-1:0] i_Datos_1,
  input  logic [WIDTH-1:0] i_Datos_2,
  input  logic [WIDTH-1:0] i_Datos_3,
  input  logic             i_Ready,
`ifdef MUX_RR_LOCK_EN
  input  logic             i_Lock,
`endif
  output logic [3:0]       o_Grant,
  output logic [1:0]       o_Sel,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Salida,
  output logic             o_Busy
);

  // Handshake: a beat transfers on any cycle where o_Valid & i_Ready are both high;
  // o_Valid follows the granted source's request, and o_Salida is stable while it is held.

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(BURST - 1);

  state_t           r_State;
  logic [3:0]       r_Grant;
  logic [1:0]       r_Sel;
  logic [1:0]       r_Last;
  logic [CNT_W-1:0] r_Cnt;

  logic [1:0]       w_Base;
  logic             w_Win_Found;
  logic [1:0]       w_Win_Idx;
  logic             w_Busy;
  logic             w_Req_Sel;
  logic [WIDTH-1:0] w_Mux;
  logic             w_Accept;
  logic             w_Cnt_Full;
  logic             w_Lock_Act;
  logic             w_Rel_Burst;
  logic             w_Rel_Drop;
  logic             w_Release;

`ifdef MUX_RR_LOCK_EN
  assign w_Lock_Act = i_Lock;
`else
  assign w_Lock_Act = 1'b0;
`endif

  assign w_Busy    = (r_State == ST_GRANT);
  assign w_Req_Sel = i_Req[r_Sel];

  // While granted the search starts after the current owner, so the release
  // decision and the next winner come out of the same cycle.
  assign w_Base = w_Busy ? r_Sel : r_Last;

  always_comb begin
    w_Win_Found = 1'b0;
    w_Win_Idx   = 2'd0;
    // Scan farthest-first so the nearest requester after w_Base overrides.
    for (int i = 3; i >= 0; i--) begin
      logic [1:0] v_idx;
      v_idx = w_Base + 2'(i + 1);
      if (i_Req[v_idx]) begin
        w_Win_Found = 1'b1;
        w_Win_Idx   = v_idx;
      end
    end
  end

  always_comb begin
    w_Mux = '0;
    case (r_Sel)
      2'd0:    w_Mux = i_Datos_0;
      2'd1:    w_Mux = i_Datos_1;
      2'd2:    w_Mux = i_Datos_2;
      default: w_Mux = i_Datos_3;
    endcase
  end

  assign w_Accept    = w_Busy & w_Req_Sel & i_Ready;
  assign w_Cnt_Full  = (r_Cnt == LP_CNT_LAST);
  assign w_Rel_Burst = w_Accept & w_Cnt_Full & ~w_Lock_Act;
  assign w_Rel_Drop  = w_Busy & ~w_Req_Sel;
  assign w_Release   = w_Rel_Burst | w_Rel_Drop;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State <= ST_IDLE;
      r_Grant <= 4'b0000;
      r_Sel   <= 2'd0;
      r_Last  <= 2'd3;
      r_Cnt   <= '0;
    end else begin
      case (r_State)
        ST_IDLE: begin
          if (w_Win_Found) begin
            r_State <= ST_GRANT;
            r_Grant <= 4'b0001 << w_Win_Idx;
            r_Sel   <= w_Win_Idx;
            r_Cnt   <= '0;
          end
        end
        ST_GRANT: begin
          if (w_Release) begin
            r_Last <= r_Sel;
            r_Cnt  <= '0;
            if (w_Win_Found) begin
              r_Grant <= 4'b0001 << w_Win_Idx;
              r_Sel   <= w_Win_Idx;
            end else begin
              // o_Sel keeps pointing at the last owner while idle.
              r_State <= ST_IDLE;
              r_Grant <= 4'b0000;
            end
          end else if (w_Accept && !w_Cnt_Full) begin
            r_Cnt <= r_Cnt + CNT_W'(1);
          end
        end
        default: begin
          r_State <= ST_IDLE;
          r_Grant <= 4'b0000;
        end
      endcase
    end
  end

  assign o_Grant  = r_Grant;
  assign o_Sel    = r_Sel;
  assign o_Busy   = w_Busy;
  assign o_Valid  = w_Busy & w_Req_Sel;
  assign o_Salida = w_Busy ? w_Mux : '0;

`ifndef SYNTHESIS
  a_grant_onehot0 : assert property (@(posedge i_Clk) $onehot0(r_Grant));
  a_grant_state   : assert property (@(posedge i_Clk) (r_Grant != 4'b0000) == w_Busy);
  a_sel_matches   : assert property (@(posedge i_Clk) w_Busy |-> (r_Grant == (4'b0001 << r_Sel)));
  a_cnt_bound     : assert property (@(posedge i_Clk) r_Cnt <= LP_CNT_LAST);
`endif

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler; expected values are hand-computed from the arbitration rules.
// Build with +define+MUX_RR_LOCK_EN to also exercise the lock scenario.
module tb_mux_rr_scheduler;

  localparam int WIDTH = 4;
  localparam int BURST = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic             ready;
`ifdef MUX_RR_LOCK_EN
  logic             lock;
`endif
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic             valid;
  logic [WIDTH-1:0] salida;
  logic             busy;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [WIDTH-1:0] dat [4];

  mux_rr_scheduler #(.WIDTH(WIDTH), .BURST(BURST), .CNT_W(CNT_W)) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Req     (req),
    .i_Datos_0 (d0),
    .i_Datos_1 (d1),
    .i_Datos_2 (d2),
    .i_Datos_3 (d3),
    .i_Ready   (ready),
`ifdef MUX_RR_LOCK_EN
    .i_Lock    (lock),
`endif
    .o_Grant   (grant),
    .o_Sel     (sel),
    .o_Valid   (valid),
    .o_Salida  (salida),
    .o_Busy    (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = 4'b0000;
    ready = 1'b0;
`ifdef MUX_RR_LOCK_EN
    lock  = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] e;
    int beats;
    logic rdy_pat [7];

    dat[0] = 4'h4; dat[1] = 4'h8; dat[2] = 4'hC; dat[3] = 4'hF;
    d0 = dat[0]; d1 = dat[1]; d2 = dat[2]; d3 = dat[3];

    // 1: reset with all requests high
    rst = 1'b1; req = 4'b1111; ready = 1'b0;
`ifdef MUX_RR_LOCK_EN
    lock = 1'b0;
`endif
    tick();
    check("rst_grant", grant, 4'b0000);
    check("rst_sel", sel, 2'd0);
    check("rst_valid", valid, 1'b0);
    check("rst_salida", salida, 4'h0);
    check("rst_busy", busy, 1'b0);
    tick();
    check("rst2_grant", grant, 4'b0000);
    rst = 1'b0;
    tick();
    check("first_grant", grant, 4'b0001);
    check("first_sel", sel, 2'd0);
    check("first_busy", busy, 1'b1);
    check("first_salida", salida, 4'h4);

    // 2: lone requester re-wins with no gap
    do_reset();
    req = 4'b0100; ready = 1'b1;
    #1;
    check("lone_idle_valid", valid, 1'b0);
    tick();
    for (int i = 0; i < 12; i++) begin
      check("lone_grant", grant, 4'b0100);
      check("lone_valid", valid, 1'b1);
      check("lone_salida", salida, 4'hC);
      tick();
    end

    // 3: all requesting, 4-cycle turns with no bubbles
    do_reset();
    req = 4'b1111; ready = 1'b1;
    for (int k = 0; k < 20; k++) exp_q.push_back(32'((k / 4) % 4));
    for (int k = 0; k < 20; k++) begin
      tick();
      e = exp_q.pop_front();
      check("rr_sel", sel, e);
      check("rr_salida", salida, dat[e[1:0]]);
    end
    tick();
    check("rr_next_sel", sel, 2'd1);

    // reset mid-burst discards the burst and restarts the search at source 0
    rst = 1'b1;
    tick();
    check("midrst_grant", grant, 4'b0000);
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", valid, 1'b0);
    rst = 1'b0;
    tick();
    check("midrst_regrant", grant, 4'b0001);

    // 4: backpressure holds the grant; exactly BURST beats
    do_reset();
    req = 4'b0110; ready = 1'b1;
    tick();
    check("bp_first", grant, 4'b0010);
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    beats = 0;
    for (int i = 0; i < 7; i++) begin
      ready = rdy_pat[i];
      #1;
      check("bp_hold", grant, 4'b0010);
      if (valid && ready) beats++;
      tick();
    end
    check("bp_beats", beats, 4);
    check("bp_next_sel", sel, 2'd2);
    check("bp_next_grant", grant, 4'b0100);

    // 5: request drop skips idle source 2, then no-winner release to IDLE
    do_reset();
    req = 4'b1010; ready = 1'b1;
    tick();
    check("drop_first", grant, 4'b0010);
    tick();
    tick();
    req = 4'b1000;
    #1;
    check("drop_valid", valid, 1'b0);
    tick();
    check("drop_grant", grant, 4'b1000);
    check("drop_sel", sel, 2'd3);
    req = 4'b0000;
    tick();
    check("idle_grant", grant, 4'b0000);
    check("idle_busy", busy, 1'b0);
    check("idle_sel_hold", sel, 2'd3);
    req = 4'b1001;
    tick();
    check("idle_regrant", grant, 4'b0001);

`ifdef MUX_RR_LOCK_EN
    // 6: lock keeps source 0 past its burst
    do_reset();
    req = 4'b0011; ready = 1'b1; lock = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("lock_hold", grant, 4'b0001);
      tick();
    end
    check("lock_after10", grant, 4'b0001);
    lock = 1'b0;
    tick();
    check("lock_release", grant, 4'b0010);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
Round-robin scheduler that shares the 4:1 data mux between four requesters. It arbitrates the i_Req lines and drives a registered one-hot grant plus the 2-bit select. Each grant is held for up to BURST accepted beats before moving on. The muxed word is presented with a valid/ready handshake to a single downstream consumer.

Parameters:
WIDTH, 4, data width of each source and of o_Salida
BURST, 4, max accepted beats per grant (>=1)
CNT_W, 3, beat counter width; must hold BURST-1

Ports:
i_Clk  input  1  system clock, rising edge
i_Rst  input  1  synchronous reset, active-high
i_Req  input  4  per-source request; source holds its data stable while requesting
i_Datos_0  input  WIDTH  source 0 data
i_Datos_1  input  WIDTH  source 1 data
i_Datos_2  input  WIDTH  source 2 data
i_Datos_3  input  WIDTH  source 3 data
i_Ready  input  1  downstream accepts the current beat
o_Grant  output  4  one-hot grant, registered
o_Sel  output  2  mux select, registered, equals index of o_Grant
o_Valid  output  1  beat valid
o_Salida  output  WIDTH  muxed data
o_Busy  output  1  high while in GRANT

Behaviour:
- One clock (i_Clk); reset synchronous, active-high (i_Rst). Reset has priority over all other inputs.
- Reset values: state=IDLE, o_Grant=0000, o_Sel=00, o_Valid=0, o_Salida=0, o_Busy=0, beat_cnt=0, last=3 (first search starts at source 0).
- States: IDLE and GRANT.
- Arbitration function:
  - Start index is (last+1) mod 4, wrapping circularly.
  - Pick the first asserted i_Req from the start index.
  - No asserted request means no winner.
- IDLE:
  - If a winner exists, on the next edge: state=GRANT, o_Grant=onehot(winner), o_Sel=winner, beat_cnt=0.
  - Request-to-grant latency is 1 cycle.
- GRANT, combinational outputs:
  - o_Valid = i_Req[o_Sel].
  - o_Salida = i_Datos_[o_Sel].
  - Both are 0 in IDLE.
- Beat accepted when o_Valid & i_Ready. On acceptance, beat_cnt increments.
- Release conditions, either one:
  - (a) Beat accepted with beat_cnt==BURST-1.
  - (b) i_Req[o_Sel]==0.
- On release:
  - last <= o_Sel.
  - Arbitrate in the same cycle from the current i_Req.
  - Winner exists: next edge loads the new grant, beat_cnt=0, no bubble cycle.
  - No winner: next edge goes to IDLE, o_Grant=0000, o_Sel holds its value.
- Sole requester: it re-wins after its burst; beat_cnt restarts; o_Grant does not drop.
- Backpressure: while i_Ready=0 with o_Valid=1, grant and beat_cnt are held.
- Request drop while i_Ready=0: release per (b); no beat is counted.
- Simultaneous final beat and request drop of the same source cannot occur, because an accepted beat requires the request.
- BURST=1: release on every accepted beat.
- beat_cnt never exceeds BURST-1.
- Reset mid-burst: the next edge restores reset values; the partial burst is discarded.
- o_Busy = (state==GRANT).

Optional Feature:
- Macro MUX_RR_LOCK_EN.
- Defined:
  - Adds port i_Lock, input, 1 bit.
  - While i_Lock=1 in GRANT, release condition (a) is suppressed and beat_cnt saturates at BURST-1.
  - The grant persists until the request drops, or until i_Lock=0 together with an accepted beat at saturation.
- Undefined: i_Lock is absent and the BURST limit is always enforced.

Test Plan:
1. i_Rst=1 for 2 cycles with i_Req=1111 -> o_Grant=0000, o_Sel=00, o_Valid=0, o_Salida=0, o_Busy=0. First grant after release of reset is source 0.
2. Lone requester: i_Req=0100, i_Datos_2=1100, i_Ready=1 -> one cycle later o_Grant=0100, o_Sel=10, o_Salida=1100, o_Valid=1 continuously. Grant is re-won after every 4 beats with no gap.
3. All requesting: i_Req=1111, data 0100/1000/1100/1111, i_Ready=1, BURST=4 -> o_Sel sequence 0,1,2,3,0. Each value lasts exactly 4 cycles with zero bubbles.
4. Backpressure: source 1 granted; i_Ready=0 for 3 cycles after beat 2 -> o_Grant held at 0010. Exactly 4 beats accepted, then o_Sel=10.
5. Request drop: i_Req=1010, source 1 granted; source 1 drops after 2 beats -> next edge o_Grant=1000 (source 3), skipping source 2.
6. MUX_RR_LOCK_EN defined: i_Req=0011, i_Lock=1 -> source 0 holds the grant for 10 beats. After i_Lock=0, the next accepted beat releases and o_Grant=0010.
